// File: rtl/iomem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iomem_arbiter_pkg                                                          |
// | Shared types and constants for the two-master iomem arbiter.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package iomem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] c_ERR_RDATA = 32'hFFFF_FFFF;

endpackage : iomem_arbiter_pkg
`default_nettype wire

// File: rtl/iomem_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iomem_rr_pick                                                              |
// | Two-way round-robin pick: a lone request wins, a tie goes away from last.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module iomem_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_grant_valid
);

  assign o_grant_valid = |i_req;
  assign o_grant       = (i_req == 2'b11) ? ~i_last_grant : i_req[1];

endmodule : iomem_rr_pick
`default_nettype wire

// File: rtl/iomem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iomem_arbiter                                                              |
// | Round-robin sharing of one iomem target between two masters, with a        |
// | watchdog that completes unacknowledged requests with an error word.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module iomem_arbiter
  import iomem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = c_ERR_RDATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout
);

  localparam int unsigned      c_CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit               c_WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [c_CNT_W-1:0] c_EXPIRE  = (TIMEOUT_CYCLES == 0) ? '0 : c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_grant;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 w_pick_idx;
  logic                 w_pick_vld;
  logic                 w_grant;
  logic                 w_done;
  logic                 w_expire;
  logic [31:0]          w_rdata;

  iomem_rr_pick u_pick (
    .i_req         ({m1_valid, m0_valid}),
    .i_last_grant  (r_last_grant),
    .o_grant       (w_pick_idx),
    .o_grant_valid (w_pick_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // An acknowledge on the expiry cycle still counts as a normal completion.
        if (s_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (c_WDOG_EN && (r_cnt == c_EXPIRE)) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_rdata = w_done ? s_rdata : ERR_RDATA;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      s_valid      <= 1'b0;
      s_wstrb      <= '0;
      s_addr       <= '0;
      s_wdata      <= '0;
      m0_ready     <= 1'b0;
      m1_ready     <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      timeout      <= 1'b0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      timeout  <= 1'b0;
      if (w_grant) begin
        s_valid      <= 1'b1;
        s_wstrb      <= w_pick_idx ? m1_wstrb : m0_wstrb;
        s_addr       <= w_pick_idx ? m1_addr  : m0_addr;
        s_wdata      <= w_pick_idx ? m1_wdata : m0_wdata;
        r_cnt        <= '0;
        r_last_grant <= w_pick_idx;
      end
      if ((r_state == ST_REQ) && !w_done && !w_expire && (r_cnt != c_CNT_MAX)) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      // While a transaction is open, r_last_grant names its owner.
      if (w_done || w_expire) begin
        s_valid <= 1'b0;
        timeout <= w_expire;
        if (r_last_grant) begin
          m1_rdata <= w_rdata;
          m1_ready <= 1'b1;
        end else begin
          m0_rdata <= w_rdata;
          m0_ready <= 1'b1;
        end
      end
    end
  end

endmodule : iomem_arbiter
`default_nettype wire

// File: tb/tb_iomem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_iomem_arbiter                                                           |
// | Randomized masters and target against a transaction-level reference model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_iomem_arbiter;

  localparam int unsigned c_TO  = 8;
  localparam logic [31:0] c_ERR = 32'hFFFF_FFFF;
  localparam int          c_CYC = 4000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  m_valid = '0;
  logic [3:0]  m_wstrb [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;

  logic        m0_ready, m1_ready, s_valid, timeout;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wstrb;

  always #5 clk = ~clk;

  iomem_arbiter #(.TIMEOUT_CYCLES(c_TO), .ERR_RDATA(c_ERR)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_valid (m_valid[0]),
    .m0_wstrb (m_wstrb[0]),
    .m0_addr  (m_addr[0]),
    .m0_wdata (m_wdata[0]),
    .m0_ready (m0_ready),
    .m0_rdata (m0_rdata),
    .m1_valid (m_valid[1]),
    .m1_wstrb (m_wstrb[1]),
    .m1_addr  (m_addr[1]),
    .m1_wdata (m_wdata[1]),
    .m1_ready (m1_ready),
    .m1_rdata (m1_rdata),
    .s_valid  (s_valid),
    .s_wstrb  (s_wstrb),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .timeout  (timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic new_req(input int m);
    m_valid[m] = 1'b1;
    m_addr[m]  = 32'h0300_0000 | ($urandom & 32'h0000_00FC);
    m_wstrb[m] = ($urandom % 2 == 0) ? 4'b0000 : 4'($urandom);
    m_wdata[m] = $urandom;
  endtask

  // Reference: an open transaction has an owner, a count of cycles the target
  // has seen the request, and a planned acknowledge delay.
  bit          e_open, e_cool, e_last;
  int          e_own, e_seen, e_wait;
  logic        e_sv, e_to;
  logic [1:0]  e_rdy;
  logic [3:0]  e_swstrb;
  logic [31:0] e_saddr, e_swdata;
  logic [31:0] e_rdata [2];
  int          n_to, n_edge_ok, n_grant [2];

  function automatic int pick_wait(input bit directed);
    int r;
    if (directed) return 0;
    r = int'($urandom % 16);
    if (r < 8)  return r % 4;
    if (r < 11) return int'(c_TO) - 1;
    if (r < 13) return int'(c_TO) + (r % 3);
    return 5;
  endfunction

  initial begin
    m_wstrb[0] = '0; m_wstrb[1] = '0;
    m_addr[0]  = '0; m_addr[1]  = '0;
    m_wdata[0] = '0; m_wdata[1] = '0;
    e_open = 0; e_cool = 0; e_last = 1; e_own = 0; e_seen = 0; e_wait = 0;
    e_sv = 0; e_to = 0; e_rdy = '0; e_swstrb = '0; e_saddr = '0; e_swdata = '0;
    e_rdata[0] = '0; e_rdata[1] = '0;
    n_to = 0; n_edge_ok = 0; n_grant[0] = 0; n_grant[1] = 0;

    for (int cyc = 0; cyc < c_CYC; cyc++) begin
      bit directed;
      @(negedge clk);
      directed = (cyc < 40);
      e_rdy = '0;
      e_to  = 1'b0;
      if (reset) begin
        e_open = 0; e_cool = 0; e_last = 1; e_sv = 0;
        e_swstrb = '0; e_saddr = '0; e_swdata = '0;
        e_rdata[0] = '0; e_rdata[1] = '0;
      end else if (e_cool) begin
        e_cool = 0;
      end else if (e_open) begin
        if (s_ready) begin
          e_open = 0; e_cool = 1; e_sv = 0;
          e_rdy[e_own] = 1'b1; e_rdata[e_own] = s_rdata;
          if (e_seen == int'(c_TO)) n_edge_ok++;
        end else if (e_seen == int'(c_TO)) begin
          e_open = 0; e_cool = 1; e_sv = 0;
          e_rdy[e_own] = 1'b1; e_rdata[e_own] = c_ERR; e_to = 1'b1;
          n_to++;
        end else begin
          e_seen++;
        end
      end else if (m_valid != 2'b00) begin
        e_own    = (m_valid == 2'b11) ? int'(!e_last) : int'(m_valid[1]);
        e_last   = e_own[0];
        e_open   = 1; e_seen = 1; e_sv = 1;
        e_wait   = pick_wait(directed);
        e_swstrb = m_wstrb[e_own]; e_saddr = m_addr[e_own]; e_swdata = m_wdata[e_own];
        n_grant[e_own]++;
      end

      chk("s_valid",  32'(s_valid),  32'(e_sv));
      chk("s_wstrb",  32'(s_wstrb),  32'(e_swstrb));
      chk("s_addr",   s_addr,        e_saddr);
      chk("s_wdata",  s_wdata,       e_swdata);
      chk("m0_ready", 32'(m0_ready), 32'(e_rdy[0]));
      chk("m1_ready", 32'(m1_ready), 32'(e_rdy[1]));
      chk("m0_rdata", m0_rdata,      e_rdata[0]);
      chk("m1_rdata", m1_rdata,      e_rdata[1]);
      chk("timeout",  32'(timeout),  32'(e_to));

      for (int m = 0; m < 2; m++) begin
        if (e_rdy[m]) begin
          if (directed || ($urandom % 2 == 0)) new_req(m);
          else m_valid[m] = 1'b0;
        end else if (!m_valid[m] && (directed || ($urandom % 3 == 0))) begin
          new_req(m);
        end
      end

      s_ready = e_open && !reset && (e_seen == e_wait + 1);
      s_rdata = $urandom;
      reset   = (cyc < 2);
      if (cyc > 40 && e_open && ($urandom % 150 == 0)) begin
        reset = 1'b1;
        for (int m = 0; m < 2; m++) if (!m_valid[m]) new_req(m);
      end
    end

    chk("saw_timeout",   32'(n_to != 0),       32'd1);
    chk("saw_edge_ack",  32'(n_edge_ok != 0),  32'd1);
    chk("served_m0",     32'(n_grant[0] != 0), 32'd1);
    chk("served_m1",     32'(n_grant[1] != 0), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_iomem_arbiter
`default_nettype wire
